// File: rtl/denorm_pkg.sv
// Shared types and constants for the denormalization stage.
package denorm_pkg;

    // Scale-register status: IDLE waits for a scale, LOADED drains the vector.
    typedef enum logic {
        IDLE   = 1'b0,
        LOADED = 1'b1
    } state_e;

    localparam int FRAC_DEF = 8;

    // Half an LSB of the Q0.FRAC input, added before truncation for round-half-up.
    function automatic int unsigned round_const(input int unsigned frac);
        return 32'd1 << (frac - 1);
    endfunction

    // Largest unsigned value representable in w bits.
    function automatic longint unsigned sat_limit(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/denorm_fifo.sv
// Synchronous FIFO with count-derived full/empty; head word is read combinationally.
module denorm_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/denorm.sv
// Rebuilds unsigned magnitudes from Q0.FRAC normalized words and the original sum.
// A pop captures the head word and the current scale; the multiply-round-saturate
// result is registered on the following edge.
module denorm
    import denorm_pkg::*;
#(
    parameter int bw    = 4,
    parameter int FRAC  = FRAC_DEF,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scale_wr,
    input  logic [2*bw-1:0] scale_in,
    input  logic            wr,
    input  logic [2*bw-1:0] in,
    input  logic            rd,
    output logic [bw-1:0]   out,
    output logic            o_valid,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_loaded,
    output logic            o_err
);
    localparam int DW = 2 * bw;
    localparam int PW = 4 * bw;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [PW:0] ROUND = (PW+1)'(round_const(FRAC));
    localparam logic [PW:0] LIMIT = (PW+1)'(sat_limit(bw));

    state_e        state_q, state_d;
    logic [DW-1:0] scale_q, scale_d;
    logic          err_q, err_d;
    logic          pipe_v_q;
    logic [DW-1:0] pipe_word_q, pipe_scale_q;
    logic [bw-1:0] out_q;
    logic          valid_q;

    logic          pop, push;
    logic [DW-1:0] f_head;
    logic [CW-1:0] f_count;
    logic          f_full, f_empty;

    logic [PW-1:0] prod;
    logic [PW:0]   rnd, shifted;
    logic [bw-1:0] sat_out;

    denorm_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in),
        .rdata_o (f_head),
        .count_o (f_count),
        .full_o  (f_full),
        .empty_o (f_empty)
    );

    // Next state, scale load and protocol-error detection.
    always_comb begin
        pop     = (state_q == LOADED) && rd && !f_empty;
        push    = wr && (!f_full || pop);
        state_d = state_q;
        scale_d = scale_q;
        err_d   = err_q;
        if (wr && !push) err_d = 1'b1;
        if (scale_wr) begin
            // A re-load mid-vector would corrupt the remaining words, so it is refused.
            if (state_q == IDLE || f_empty) begin
                scale_d = scale_in;
                state_d = LOADED;
            end else begin
                err_d = 1'b1;
            end
        end
        if (pop && f_count == CW'(1) && !push) state_d = IDLE;
    end

    // Multiply, round half up, saturate to bw bits.
    always_comb begin
        prod    = PW'(pipe_word_q) * PW'(pipe_scale_q);
        rnd     = {1'b0, prod} + ROUND;
        shifted = rnd >> FRAC;
        sat_out = (shifted > LIMIT) ? bw'(LIMIT) : shifted[bw-1:0];
    end

    // Control state, capture stage and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            scale_q      <= '0;
            err_q        <= 1'b0;
            pipe_v_q     <= 1'b0;
            pipe_word_q  <= '0;
            pipe_scale_q <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            scale_q  <= scale_d;
            err_q    <= err_d;
            pipe_v_q <= pop;
            if (pop) begin
                pipe_word_q  <= f_head;
                pipe_scale_q <= scale_q;
            end
            valid_q <= pipe_v_q;
            if (pipe_v_q) out_q <= sat_out;
        end
    end

    assign out      = out_q;
    assign o_valid  = valid_q;
    assign o_full   = f_full;
    assign o_empty  = f_empty;
    assign o_loaded = (state_q == LOADED);
    assign o_err    = err_q;

endmodule

// File: tb/tb_denorm.sv
// Self-checking bench for denorm: directed vector table, hand sequences for
// overflow / misuse / reset, and random traffic against a queue-based model.
module tb_denorm;
    localparam int BW    = 4;
    localparam int FRAC  = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0, scale_wr = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [2*BW-1:0] scale_in = '0, din = '0;
    logic [BW-1:0] out;
    logic o_valid, o_full, o_empty, o_loaded, o_err;

    always #5 clk = ~clk;

    denorm #(.bw(BW), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .scale_wr(scale_wr), .scale_in(scale_in),
        .wr(wr), .in(din), .rd(rd), .out(out), .o_valid(o_valid),
        .o_full(o_full), .o_empty(o_empty), .o_loaded(o_loaded), .o_err(o_err)
    );

    // Reference model state
    int unsigned mq[$];
    bit          m_loaded, m_err, m_pv, m_valid;
    int unsigned m_scale, m_pr, m_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit sw; int unsigned si; bit w; int unsigned d; bit rr;
        bit chk; int unsigned eo; bit ev; bit el; bit ee;
    } vec_t;
    vec_t tv[$];

    function automatic int unsigned recon(int unsigned w, int unsigned s);
        longint unsigned r;
        r = (64'(w) * 64'(s) + 64'(1 << (FRAC - 1))) / 64'(1 << FRAC);
        if (r > 64'((1 << BW) - 1)) return (1 << BW) - 1;
        return int'(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input int unsigned want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit sw, input int unsigned si,
                              input bit w, input int unsigned d, input bit rr);
        int  n0;
        bit  was_loaded, pop, push;
        int unsigned old_scale;
        if (r) begin
            mq.delete();
            m_loaded = 0; m_err = 0; m_pv = 0; m_valid = 0;
            m_scale = 0; m_pr = 0; m_out = 0;
            return;
        end
        n0 = mq.size();
        was_loaded = m_loaded;
        old_scale = m_scale;
        pop  = was_loaded && n0 > 0 && rr;
        push = w && (n0 < DEPTH || pop);
        m_valid = m_pv;
        if (m_pv) m_out = m_pr;
        m_pv = pop;
        if (pop) m_pr = recon(mq.pop_front(), old_scale);
        if (push) mq.push_back(d);
        if (w && !push) m_err = 1;
        if (sw) begin
            if (!was_loaded || n0 == 0) begin
                m_scale = si; m_loaded = 1;
            end else begin
                m_err = 1;
            end
        end
        if (was_loaded && pop && mq.size() == 0) m_loaded = 0;
    endtask

    task automatic step(input bit r, input bit sw, input int unsigned si,
                        input bit w, input int unsigned d, input bit rr, input string nm);
        reset = r; scale_wr = sw; scale_in = si[2*BW-1:0];
        wr = w; din = d[2*BW-1:0]; rd = rr;
        @(posedge clk);
        model_step(r, sw, si, w, d, rr);
        #1;
        chk({nm, " out"},    out,      m_out);
        chk({nm, " valid"},  o_valid,  32'(m_valid));
        chk({nm, " full"},   o_full,   32'(mq.size() == DEPTH));
        chk({nm, " empty"},  o_empty,  32'(mq.size() == 0));
        chk({nm, " loaded"}, o_loaded, 32'(m_loaded));
        chk({nm, " err"},    o_err,    32'(m_err));
    endtask

    task automatic nop(input string nm);
        step(0, 0, 0, 0, 0, 0, nm);
    endtask

    initial begin
        // round trip: 96,32,128 with scale 8 -> 3,1,4
        tv.push_back('{1,   8, 0,   0, 0, 1,  0, 0, 1, 1});
        tv.push_back('{0,   0, 1,  96, 0, 0,  0, 0, 0, 0});
        tv.push_back('{0,   0, 1,  32, 0, 0,  0, 0, 0, 0});
        tv.push_back('{0,   0, 1, 128, 0, 1,  0, 0, 1, 0});
        tv.push_back('{0,   0, 0,   0, 1, 1,  0, 0, 1, 0});
        tv.push_back('{0,   0, 0,   0, 1, 1,  3, 1, 1, 0});
        tv.push_back('{0,   0, 0,   0, 1, 1,  1, 1, 0, 1});
        tv.push_back('{0,   0, 0,   0, 0, 1,  4, 1, 0, 1});
        tv.push_back('{0,   0, 0,   0, 0, 1,  4, 0, 0, 1});
        // rounding: 100*8 -> 3
        tv.push_back('{1,   8, 1, 100, 0, 1,  4, 0, 1, 0});
        tv.push_back('{0,   0, 0,   0, 1, 1,  4, 0, 0, 1});
        tv.push_back('{0,   0, 0,   0, 0, 1,  3, 1, 0, 1});
        // saturation: 255*255 -> 254 -> 15
        tv.push_back('{1, 255, 1, 255, 0, 0,  0, 0, 0, 0});
        tv.push_back('{0,   0, 0,   0, 1, 0,  0, 0, 0, 0});
        tv.push_back('{0,   0, 0,   0, 0, 1, 15, 1, 0, 1});
        // scale zero
        tv.push_back('{1,   0, 1, 200, 0, 1, 15, 0, 1, 0});
        tv.push_back('{0,   0, 0,   0, 1, 0,  0, 0, 0, 0});
        tv.push_back('{0,   0, 0,   0, 0, 1,  0, 1, 0, 1});

        step(1, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < tv.size(); i++) begin
            step(0, tv[i].sw, tv[i].si, tv[i].w, tv[i].d, tv[i].rr, "vec");
            if (tv[i].chk) begin
                chk("vec table out",    out,      tv[i].eo);
                chk("vec table valid",  o_valid,  32'(tv[i].ev));
                chk("vec table loaded", o_loaded, 32'(tv[i].el));
                chk("vec table empty",  o_empty,  32'(tv[i].ee));
            end
        end

        // overflow: 9 writes, 9th dropped, then ordered drain
        step(1, 0, 0, 0, 0, 0, "ovf reset");
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 2 + i, 0, "ovf wr");
            if (i == 7) begin
                chk("ovf full after 8", o_full, 1);
                chk("ovf err before drop", o_err, 0);
            end
        end
        chk("ovf err after drop", o_err, 1);
        step(0, 1, 255, 0, 0, 0, "ovf scale");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, "ovf rd");
        step(0, 0, 0, 0, 0, 1, "ovf extra rd");
        chk("ovf last word", out, recon(9, 255));
        nop("ovf tail");
        chk("ovf extra rd no valid", o_valid, 0);

        // wr+rd on full FIFO
        step(1, 0, 0, 0, 0, 0, "full reset");
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 20 + i, 0, "full wr");
        step(0, 1, 8, 0, 0, 0, "full scale");
        step(0, 0, 0, 1, 99, 1, "full wr+rd");
        chk("full wr+rd full", o_full, 1);
        chk("full wr+rd err", o_err, 0);

        // protocol misuse
        step(1, 0, 0, 0, 0, 0, "mis reset");
        step(0, 0, 0, 1, 96, 0, "mis wr");
        step(0, 0, 0, 1, 200, 0, "mis wr");
        step(0, 0, 0, 0, 0, 1, "mis idle rd");
        nop("mis idle");
        chk("mis idle rd valid", o_valid, 0);
        chk("mis idle rd empty", o_empty, 0);
        step(0, 1, 8, 0, 0, 0, "mis scale");
        step(0, 0, 0, 0, 0, 1, "mis rd1");
        step(0, 1, 4, 0, 0, 0, "mis reload");
        chk("mis reload err", o_err, 1);
        step(0, 0, 0, 0, 0, 1, "mis rd2");
        nop("mis tail");
        chk("mis old scale used", out, 6);

        // reset mid-drain
        step(1, 0, 0, 0, 0, 0, "rst reset");
        step(0, 1, 8, 0, 0, 0, "rst scale");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 200, 0, "rst wr");
        step(0, 1, 4, 0, 0, 0, "rst misuse");
        step(0, 0, 0, 0, 0, 1, "rst rd");
        step(0, 0, 0, 0, 0, 1, "rst rd");
        step(1, 0, 0, 0, 0, 1, "rst mid");
        chk("rst mid empty", o_empty, 1);
        chk("rst mid loaded", o_loaded, 0);
        chk("rst mid valid", o_valid, 0);
        chk("rst mid out", out, 0);
        chk("rst mid err", o_err, 0);
        nop("rst after");
        chk("rst in-flight dropped", o_valid, 0);

        // random traffic against the model
        step(1, 0, 0, 0, 0, 0, "rnd reset");
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 255), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 255), $urandom_range(0, 2) != 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/denorm.md
Name: denorm

Overview:
Inverse of the normalization stage: rebuilds unsigned magnitudes from fractional normalized values (value·2^FRAC/sum) and the sum used to produce them.
- Normalized words are buffered in an internal FIFO.
- A scale word (the original sum) is loaded once per vector.
- Each read pops one word and returns round((word·scale)/2^FRAC), saturated to bw bits, one cycle later.
- Sits downstream of the normalization output, ahead of the next-layer accumulate path.

Parameters:
bw, 4, magnitude width of reconstructed output; normalized input and scale are 2*bw wide
FRAC, 8, fractional bits of normalized input (Q0.FRAC); must satisfy 1 <= FRAC <= 2*bw
DEPTH, 8, FIFO depth in words, power of two >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
scale_wr  input  1  load scale_in into scale register
scale_in  input  2*bw  unsigned sum used by the normalizer
wr  input  1  push in into FIFO
in  input  2*bw  unsigned normalized value, Q0.FRAC
rd  input  1  request pop and reconstruction of head word
out  output  bw  reconstructed unsigned magnitude
o_valid  output  1  out updated this cycle (one-cycle pulse)
o_full  output  1  FIFO holds DEPTH words
o_empty  output  1  FIFO holds 0 words
o_loaded  output  1  scale register valid
o_err  output  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high, clock clk):
  - out=0, o_valid=0, o_err=0, o_loaded=0.
  - scale=0, FIFO pointers and count=0, so o_empty=1 and o_full=0.
  - Reset mid-drain discards all FIFO contents and any in-flight result; o_valid=0 the following cycle.
- States: IDLE (no scale loaded, o_loaded=0) and LOADED (o_loaded=1).
  - IDLE -> LOADED on scale_wr.
  - LOADED -> IDLE on the cycle a pop empties the FIFO (end of vector).
  - LOADED stays LOADED on scale_wr only if FIFO empty (re-load; new scale used from next cycle).
- scale_wr while FIFO non-empty in LOADED: ignored, scale unchanged, o_err<=1.
- scale_wr in IDLE is always accepted, FIFO contents irrelevant; words may be pre-buffered before the scale arrives.
- wr:
  - Accepted in any state when count<DEPTH.
  - Accepted when full if rd pops in the same cycle.
  - Otherwise dropped and o_err<=1.
  - Count/flags update the next cycle.
- rd:
  - Pops only when LOADED and count>0.
  - rd when empty or IDLE: no pop, no o_valid, out holds, no error.
  - wr+rd on empty FIFO: push only, no bypass.
- Latency: pop at edge N; out and o_valid=1 visible after edge N+1; o_valid deasserts next cycle unless another pop. Back-to-back rd gives one result per cycle.
- Arithmetic:
  - p = in*scale, 4*bw bits unsigned.
  - r = (p + 2^(FRAC-1)) >> FRAC, round half up.
  - out = min(r, 2^bw - 1).
  - scale=0 gives out=0.
  - The scale sampled is the one held in the pop cycle.
- o_err is cleared only by reset.
- FIFO pointers wrap modulo DEPTH; full/empty are derived from a count, not pointer equality alone.

Decomposition:
- Package denorm_pkg:
  - state encoding (IDLE=0, LOADED=1)
  - default FRAC and rounding constant 2^(FRAC-1)
  - saturation limit function of bw
- One sub-module: denorm_fifo, a synchronous FIFO (DEPTH x 2*bw) with push/pop/count/full/empty.
- Multiply-round-saturate and state machine live in the top.

Test Plan:
- Vector round-trip, bw=4, FRAC=8:
  - scale_wr 8, then wr 96, 32, 128, then 3 consecutive rd.
  - Expect out=3, 1, 4 with o_valid on cycles rd+1.
  - o_loaded falls after the 3rd pop; o_empty=1.
- Rounding: scale 8, in 100 -> (800+128)>>8 = out 3. Saturation: scale 255, in 255 -> 254 capped to out 15.
- Overflow (DEPTH=8):
  - 9 wr with no rd: o_full=1 after 8th, 9th dropped, o_err=1.
  - Then 8 rd return the first 8 words in order; a further rd gives no o_valid.
  - Also: wr+rd on a full FIFO keeps o_full=1 with o_err unchanged.
- Protocol misuse:
  - rd in IDLE with 2 words buffered: no pop, o_valid=0.
  - scale_wr 4 mid-vector (1 word left): ignored, o_err=1, remaining word uses old scale.
- Reset mid-drain: with 4 words buffered and rd active, assert reset one cycle. Expect o_empty=1, o_loaded=0, o_valid=0, out=0, o_err=0 next cycle.
- Scale 0: scale_wr 0, wr 200, rd -> out=0, o_valid=1.
